// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list for a 4-wide allocation stage. A circular
//   array of free physical register numbers is consumed at `head` by the
//   allocator (up to four per cycle, program order) and refilled at `tail`
//   by commit (up to two per cycle). The head pointer is published as
//   `curr_pos` so the branch unit can checkpoint it and later rewind it
//   through `flush` / `flush_pos`.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   alloc_valid         allocation group present this cycle
//   pr_need_inst[3:0]   per-instruction destination request (bit 0 oldest)
//   pr0..pr3            register handed to instruction k (valid when its
//                       need bit is set and alloc_ok is high)
//   alloc_ok            whole group granted this cycle
//   alloc_stall         alloc_valid & !alloc_ok
//   curr_pos            registered head pointer
//   free_vld[1:0]       commit release strobes (bit 0 older)
//   free_pr0, free_pr1  released register numbers
//   flush, flush_pos    mispredict recovery: restore head to flush_pos
//   free_cnt            registered number of free entries
//   ovf_err             sticky: a release arrived while the list was full
// -----------------------------------------------------------------------------
module free_list #(
  parameter int PR_W     = 6,
  parameter int NUM_ARCH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_valid,
  input  logic [3:0]      pr_need_inst,
  output logic [PR_W-1:0] pr0,
  output logic [PR_W-1:0] pr1,
  output logic [PR_W-1:0] pr2,
  output logic [PR_W-1:0] pr3,
  output logic            alloc_ok,
  output logic            alloc_stall,
  output logic [PR_W-1:0] curr_pos,
  input  logic [1:0]      free_vld,
  input  logic [PR_W-1:0] free_pr0,
  input  logic [PR_W-1:0] free_pr1,
  input  logic            flush,
  input  logic [PR_W-1:0] flush_pos,
  output logic [PR_W:0]   free_cnt,
  output logic            ovf_err
);

  localparam int            DEPTH    = 1 << PR_W;
  localparam int            CW       = PR_W + 1;
  localparam logic [CW-1:0] MAX_FREE = CW'(DEPTH - NUM_ARCH);

  logic [PR_W-1:0] fl_mem_q [DEPTH];
  logic [PR_W-1:0] head_q, head_d;
  logic [PR_W-1:0] tail_q, tail_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic            ovf_q,  ovf_d;

  // Prefix sums of the need bits: slot offset of each instruction from head.
  logic [2:0] off1, off2, off3, n_need, alloc_n;
  logic       acc0, acc1;
  logic [1:0] n_rel;
  logic [PR_W-1:0] wr1_idx;

  always_comb begin
    off1   = {2'b00, pr_need_inst[0]};
    off2   = off1 + {2'b00, pr_need_inst[1]};
    off3   = off2 + {2'b00, pr_need_inst[2]};
    n_need = off3 + {2'b00, pr_need_inst[3]};
  end

  assign pr0 = fl_mem_q[head_q];
  assign pr1 = fl_mem_q[head_q + PR_W'(off1)];
  assign pr2 = fl_mem_q[head_q + PR_W'(off2)];
  assign pr3 = fl_mem_q[head_q + PR_W'(off3)];

  // Grant uses the registered count only; same-cycle releases do not bypass.
  assign alloc_ok    = alloc_valid & ~flush & (cnt_q >= CW'(n_need));
  assign alloc_stall = alloc_valid & ~alloc_ok;

  // Releases are judged oldest first; a dropped bit 0 leaves room for bit 1
  // only if the count still allows it, and bit 1 then lands at tail itself.
  assign acc0    = free_vld[0] & (cnt_q < MAX_FREE);
  assign acc1    = free_vld[1] & ((cnt_q + CW'(acc0)) < MAX_FREE);
  assign n_rel   = {1'b0, acc0} + {1'b0, acc1};
  assign wr1_idx = tail_q + PR_W'(acc0);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    alloc_n = 3'd0;
    tail_d  = tail_q + PR_W'(n_rel);
    head_d  = head_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (free_vld[0] & ~acc0) | (free_vld[1] & ~acc1);
    if (flush) begin
      // Entries between flush_pos and the old head become free again; the
      // count is simply the distance from the restored head to the new tail.
      head_d = flush_pos;
      cnt_d  = {1'b0, tail_d - flush_pos};
    end else begin
      if (alloc_ok) begin
        alloc_n = n_need;
      end
      head_d = head_q + PR_W'(alloc_n);
      cnt_d  = cnt_q - CW'(alloc_n) + CW'(n_rel);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= PR_W'(DEPTH - NUM_ARCH);
      cnt_q  <= MAX_FREE;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // NOTE: the array is reset on purpose: after reset it must already hold the
  // registers not claimed by the architectural map, so it cannot be a plain
  // un-reset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fl_mem_q[i] <= (i < int'(MAX_FREE)) ? PR_W'(NUM_ARCH + i) : '0;
      end
    end else begin
      if (acc0) fl_mem_q[tail_q]  <= free_pr0;
      if (acc1) fl_mem_q[wr1_idx] <= free_pr1;
    end
  end

  assign curr_pos = head_q;
  assign free_cnt = cnt_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list. A behavioural model (plain integer array and
//   modulo-64 pointers) tracks the list; a negedge compare process checks all
//   outputs against it every cycle, and the stimulus pins the model with
//   hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic [3:0] pr_need_inst;
  logic [5:0] pr0, pr1, pr2, pr3;
  logic       alloc_ok, alloc_stall;
  logic [5:0] curr_pos;
  logic [1:0] free_vld;
  logic [5:0] free_pr0, free_pr1;
  logic       flush;
  logic [5:0] flush_pos;
  logic [6:0] free_cnt;
  logic       ovf_err;

  free_list #(.PR_W(6), .NUM_ARCH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .pr_need_inst (pr_need_inst),
    .pr0          (pr0),
    .pr1          (pr1),
    .pr2          (pr2),
    .pr3          (pr3),
    .alloc_ok     (alloc_ok),
    .alloc_stall  (alloc_stall),
    .curr_pos     (curr_pos),
    .free_vld     (free_vld),
    .free_pr0     (free_pr0),
    .free_pr1     (free_pr1),
    .flush        (flush),
    .flush_pos    (flush_pos),
    .free_cnt     (free_cnt),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Behavioural model of the list contents and pointers.
  int m_fl [64];
  int m_head, m_tail, m_cnt;
  bit m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_fl[i] = (i < 32) ? 32 + i : 0;
    m_head = 0;
    m_tail = 32;
    m_cnt  = 32;
    m_ovf  = 1'b0;
  endtask

  function automatic int need_cnt(input logic [3:0] need);
    int c = 0;
    for (int k = 0; k < 4; k++) if (need[k]) c++;
    return c;
  endfunction

  // One clock edge of list behaviour, from the inputs present at the edge.
  task automatic model_step();
    int  n, acc;
    bit  grant;
    n     = need_cnt(pr_need_inst);
    grant = alloc_valid && !flush && (m_cnt >= n);
    acc   = 0;
    for (int b = 0; b < 2; b++) begin
      if (free_vld[b]) begin
        if (m_cnt + acc < 32) begin
          m_fl[(m_tail + acc) % 64] = (b == 0) ? int'(free_pr0) : int'(free_pr1);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_tail = (m_tail + acc) % 64;
    if (flush) begin
      m_head = int'(flush_pos);
      m_cnt  = (m_tail - int'(flush_pos) + 64) % 64;
    end else begin
      if (grant) begin
        m_head = (m_head + n) % 64;
        m_cnt  = m_cnt - n;
      end
      m_cnt = m_cnt + acc;
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp_blk
    int   off;
    logic exp_ok;
    logic [5:0] pr_act;
    if (cmp_en && rst_n) begin
      exp_ok = alloc_valid && !flush && (m_cnt >= need_cnt(pr_need_inst));
      check("alloc_ok", alloc_ok, exp_ok);
      check("alloc_stall", alloc_stall, alloc_valid && !exp_ok);
      check("curr_pos", curr_pos, m_head);
      check("free_cnt", free_cnt, m_cnt);
      check("ovf_err", ovf_err, m_ovf);
      off = 0;
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: pr_act = pr0;
          1: pr_act = pr1;
          2: pr_act = pr2;
          default: pr_act = pr3;
        endcase
        if (pr_need_inst[k]) begin
          if (exp_ok) check($sformatf("pr%0d", k), pr_act, m_fl[(m_head + off) % 64]);
          off++;
        end
      end
    end
  end

  // Drive one cycle's inputs just after a posedge, then wait for the negedge.
  task automatic apply(input logic av, input logic [3:0] need, input logic [1:0] fv,
                       input logic [5:0] f0, input logic [5:0] f1,
                       input logic fl, input logic [5:0] fp);
    alloc_valid  = av;
    pr_need_inst = need;
    free_vld     = fv;
    free_pr0     = f0;
    free_pr1     = f1;
    flush        = fl;
    flush_pos    = fp;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic av, input logic [3:0] need, input logic [1:0] fv,
                     input logic [5:0] f0, input logic [5:0] f1,
                     input logic fl, input logic [5:0] fp);
    apply(av, need, fv, f0, f1, fl, fp);
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    alloc_valid  = 1'b0;
    pr_need_inst = 4'b0000;
    free_vld     = 2'b00;
    free_pr0     = '0;
    free_pr1     = '0;
    flush        = 1'b0;
    flush_pos    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state and first grant.
    apply(1, 4'b1011, 0, 0, 0, 0, 0);
    check("reset curr_pos", curr_pos, 0);
    check("reset free_cnt", free_cnt, 32);
    check("reset ovf_err", ovf_err, 0);
    check("first pr0", pr0, 32);
    check("first pr1", pr1, 33);
    check("first pr3", pr3, 34);
    check("first alloc_ok", alloc_ok, 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("after first curr_pos", curr_pos, 3);
    check("after first free_cnt", free_cnt, 29);
    tick();

    // Asynchronous reset in the middle of a clock phase.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async rst curr_pos", curr_pos, 0);
    check("async rst free_cnt", free_cnt, 32);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Drain all 32 free registers, then stall.
    for (int g = 0; g < 8; g++) begin
      apply(1, 4'b1111, 0, 0, 0, 0, 0);
      if (g == 0) check("drain g0 pr0", pr0, 32);
      if (g == 7) check("drain g7 pr3", pr3, 63);
      tick();
    end
    apply(1, 4'b1111, 0, 0, 0, 0, 0);
    check("empty stall", alloc_stall, 1);
    check("empty free_cnt", free_cnt, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("stall head held", curr_pos, 32);
    tick();

    // Two releases land at slots 32, 33 and are handed out next.
    cyc(0, 0, 2'b11, 6'd5, 6'd9, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check("release free_cnt", free_cnt, 2);
    tick();
    apply(1, 4'b0011, 0, 0, 0, 0, 0);
    check("reuse pr0", pr0, 5);
    check("reuse pr1", pr1, 9);
    tick();

    // Flush to 10, allocate to 14, then flush back while allocating.
    cyc(0, 0, 0, 0, 0, 1, 6'd10);
    apply(1, 4'b1111, 0, 0, 0, 0, 0);
    check("post-flush pr0", pr0, 42);
    tick();
    apply(1, 4'b1111, 0, 0, 0, 1, 6'd10);
    check("flush suppresses alloc", alloc_ok, 0);
    tick();
    apply(1, 4'b0001, 0, 0, 0, 0, 0);
    check("rewound curr_pos", curr_pos, 10);
    check("rewound pr0", pr0, 42);
    tick();

    // Empty the list, refill 32 entries across the tail wrap, overflow.
    cyc(0, 0, 0, 0, 0, 1, 6'd34);
    for (int i = 0; i < 15; i++) cyc(0, 0, 2'b11, 6'(2 * i), 6'(2 * i + 1), 0, 0);
    cyc(0, 0, 2'b01, 6'd30, 0, 0, 0);
    apply(0, 0, 2'b11, 6'd31, 6'd50, 0, 0);
    check("pre-ovf ovf_err", ovf_err, 0);
    tick();
    apply(0, 0, 2'b01, 6'd7, 0, 0, 0);
    check("full ovf_err", ovf_err, 1);
    check("full free_cnt", free_cnt, 32);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("ovf sticky", ovf_err, 1);
    check("dropped free_cnt", free_cnt, 32);
    tick();

    // Head wrap 62 -> 2.
    cyc(0, 0, 0, 0, 0, 1, 6'd62);
    apply(1, 4'b1111, 0, 0, 0, 0, 0);
    check("wrap pr0", pr0, 28);
    check("wrap pr1", pr1, 29);
    check("wrap pr2", pr2, 30);
    check("wrap pr3", pr3, 31);
    tick();
    apply(1, 4'b0000, 0, 0, 0, 0, 0);
    check("n0 alloc_ok", alloc_ok, 1);
    check("wrap curr_pos", curr_pos, 2);
    tick();
    apply(1, 4'b0001, 0, 0, 0, 0, 0);
    check("cnt0 stall", alloc_stall, 1);
    tick();

    // Three free, four needed: stall; then three needed: grant across wrap.
    cyc(0, 0, 0, 0, 0, 1, 6'd63);
    apply(1, 4'b1111, 0, 0, 0, 0, 0);
    check("cnt3 stall", alloc_stall, 1);
    check("cnt3 free_cnt", free_cnt, 3);
    tick();
    apply(1, 4'b0111, 0, 0, 0, 0, 0);
    check("cnt3 pr0", pr0, 29);
    check("cnt3 pr2", pr2, 31);
    tick();

    // Advance tail to 40, then flush to 20 with two same-cycle releases.
    for (int i = 0; i < 16; i++) cyc(0, 0, 2'b11, 6'(40 + i), 6'(i), 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 6'd34);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b11, 6'(20 + i), 6'(60 - i), 0, 0);
    cyc(0, 0, 2'b11, 6'd11, 6'd12, 1, 6'd20);
    apply(0, 0, 0, 0, 0, 0, 0);
    check("flush+rel free_cnt", free_cnt, 22);
    check("flush+rel curr_pos", curr_pos, 20);
    tick();

    // Allocation and release in the same cycle.
    cyc(1, 4'b1111, 2'b01, 6'd13, 0, 0, 0);
    cyc(1, 4'b1010, 2'b10, 0, 6'd14, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
